// File: rtl/gcd_pkg.sv
// Shared constants and FSM state type for the gcd sequencer.
package gcd_pkg;

  localparam int unsigned W_DEF    = 16;
  localparam int unsigned IW_DEF   = 8;
  localparam int unsigned ITER_MAX = (1 << IW_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MOD   = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mod_seq.sv
// Iterative unsigned restoring remainder: r = x mod y, valid exactly W cycles after go.
module mod_seq
  import gcd_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         valid,
  output logic [W-1:0] r
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  xs_q;
  logic [W-1:0]  y_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  logic [W-1:0]  src_rem;
  logic          src_bit;
  logic [W-1:0]  src_y;
  logic [W:0]    trial;
  logic [W-1:0]  rem_next;

  // One restoring step; the go cycle feeds operands straight from the inputs.
  always_comb begin
    src_rem  = go ? '0 : rem_q;
    src_bit  = go ? x[W-1] : xs_q[W-1];
    src_y    = go ? y : y_q;
    trial    = {src_rem, src_bit};
    rem_next = trial[W-1:0];
    if (trial >= {1'b0, src_y}) begin
      rem_next = W'(trial - {1'b0, src_y});
    end
  end

  // Bit-serial iteration, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      xs_q     <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      valid    <= 1'b0;
      r        <= '0;
    end else begin
      valid <= 1'b0;
      if (go) begin
        rem_q    <= rem_next;
        xs_q     <= {x[W-2:0], 1'b0};
        y_q      <= y;
        cnt_q    <= CW'(W - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= rem_next;
        xs_q  <= {xs_q[W-2:0], 1'b0};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          active_q <= 1'b0;
          valid    <= 1'b1;
          r        <= rem_next;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_mod_sched.sv
// Euclid gcd of two signed operands, reusing the serial remainder unit each step.
module gcd_mod_sched
  import gcd_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  gcd,
  output logic [IW-1:0] iters,
  output logic          err
);

  localparam logic [IW-1:0] IMAX = {IW{1'b1}};

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          go_c;
  logic          mvalid;
  logic [W-1:0]  mr;

  // Two's complement magnitude; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  mod_seq #(.W(W)) u_mod (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go_c),
    .x     (a_q),
    .y     (b_q),
    .valid (mvalid),
    .r     (mr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and remainder-unit launch.
  always_comb begin
    state_d = state_q;
    go_c    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: begin
        if (b_q == '0) begin
          state_d = FIN;
        end else begin
          go_c    = 1'b1;
          state_d = MOD;
        end
      end
      MOD:   if (mvalid) state_d = CHECK;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand swap, iteration count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gcd   <= '0;
      iters <= '0;
      err   <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == FIN);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= mag(a);
            b_q   <= mag(b);
            iters <= '0;
            err   <= 1'b0;
            gcd   <= '0;
          end
        end
        CHECK: begin
          if (b_q == '0) begin
            gcd <= a_q;
            err <= (a_q == '0);
          end
        end
        MOD: begin
          if (mvalid) begin
            a_q <= b_q;
            b_q <= mr;
            if (iters != IMAX) iters <= iters + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_mod_sched.sv
// Scoreboard bench for gcd_mod_sched against a plain-arithmetic Euclid model.
module tb_gcd_mod_sched;

  localparam int W    = 16;
  localparam int STEP = W + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  gcd;
  logic [7:0]    iters;
  logic          err;

  typedef struct {
    int g;
    int k;
    int e;
    int acc;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  bit   have_last;
  bit   prev_done;
  int   brun;
  int   done_cnt;
  int   cyc;
  int   tests;
  int   fails;

  gcd_mod_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gcd   (gcd),
    .iters (iters),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: Euclid on magnitudes with plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int x, y, t, k;
    x = int'($signed(av));
    y = int'($signed(bv));
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    k = 0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
      k++;
    end
    e.g = x;
    e.k = (k > 255) ? 255 : k;
    e.e = (x == 0) ? 1 : 0;
    e.acc = 0;
    e.due = 0;
    return e;
  endfunction

  // Monitor: pops expectations on done, checks timing, busy span and hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) brun++;
      if (done) begin
        if (prev_done) chk("done_one_cycle", 32'(done & ~prev_done), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("gcd", 32'(gcd), 32'(e.g));
          chk("iters", 32'(iters), 32'(e.k));
          chk("err", 32'(err), 32'(e.e));
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("busy_span", 32'(brun), 32'(e.due - e.acc));
          last = e;
          have_last = 1'b1;
        end
        done_cnt++;
      end else if (!busy && have_last) begin
        chk("hold", {8'(gcd), 8'(gcd >> 8), 8'(iters), 8'(err)},
            {8'(last.g), 8'(last.g >> 8), 8'(last.k), 8'(last.e)});
      end
      if (!busy) brun = 0;
      prev_done = done;
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e = model(av, bv);
    a = av;
    b = bv;
    start = 1'b1;
    e.acc = cyc;
    e.due = cyc + 2 + e.k * STEP;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (done_cnt != tgt) return;
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: no done within 2000 cycles (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit pulse);
    int t;
    exp_t e;
    @(negedge clk);
    t = done_cnt;
    issue(av, bv);
    e = model(av, bv);
    @(negedge clk);
    start = 1'b0;
    if (pulse && e.k >= 1) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(t);
  endtask

  initial begin
    int t;
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; brun = 0;
    have_last = 1'b0; prev_done = 1'b0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gcd", 32'(gcd), 32'd0);
    chk("rst_iters", 32'(iters), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(16'd25, 16'd5, 1'b0);
    run_op(16'd301, 16'd39, 1'b1);
    run_op(-16'sd1872, 16'd624, 1'b0);
    run_op(16'd0, 16'd7, 1'b0);
    run_op(16'd0, 16'd0, 1'b0);
    run_op(16'h8000, 16'd0, 1'b0);
    run_op(16'h8000, 16'hC000, 1'b1);

    // Start held high across two back-to-back operations.
    @(negedge clk);
    t = done_cnt;
    issue(16'd400, 16'd99);
    wait_done(t);
    t = done_cnt;
    @(negedge clk);
    issue(16'd400, 16'd99);
    @(negedge clk);
    start = 1'b0;
    wait_done(t);

    // Asynchronous reset in the middle of the second modulo step.
    @(negedge clk);
    issue(16'd7257, 16'd1893);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    have_last = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_gcd", 32'(gcd), 32'd0);
    chk("abort_iters", 32'(iters), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'(t + 1));
    run_op(16'd9956, 16'd2489, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) begin
        ra = 16'($urandom_range(0, 60));
        rb = 16'($urandom_range(0, 60));
        if ($urandom_range(0, 1) == 1) ra = -ra;
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
